// File: rtl/i_cache_dm_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// State encodings, bus constants and the latched-request record.
package i_cache_dm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REFILL = 3'd2,
    S_RWAIT  = 3'd3,
    S_RESP   = 3'd4,
    S_UNC    = 3'd5,
    S_UWAIT  = 3'd6
  } state_t;

  localparam logic [2:0] KSEG1_TOP = 3'b101;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_kseg1(input logic [31:0] addr);
    return addr[31:29] == KSEG1_TOP;
  endfunction

endpackage

// File: rtl/i_cache_dm_array.sv
// Tag/data store: one flop-based line per set, asynchronous read, full-line write.
// Latency: read is combinational, write and clear-all take effect on the next edge.
// Backpressure: none; the controller never writes and clears in the same cycle.
module i_cache_dm_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 22,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  // Only the valid bits are reset; tag/data contents are don't-care until valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped read-only instruction cache between the cpu sram-like port and the mem port.
// Latency: hit returns data_ok one cycle after addr_ok; miss refills LINE_WORDS single reads.
// Backpressure: addr_ok only in IDLE; downstream req is held until mem_inst_addr_ok.
module i_cache_dm
  import i_cache_dm_pkg::*;
#(
  parameter int INDEX_W   = 6,
  parameter int OFFSET_W  = 2,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic [31:0] cpu_inst_rdata,
  output logic        mem_inst_req,
  output logic        mem_inst_wr,
  output logic [1:0]  mem_inst_size,
  output logic [31:0] mem_inst_addr,
  output logic [31:0] mem_inst_wdata,
  input  logic        mem_inst_addr_ok,
  input  logic        mem_inst_data_ok,
  input  logic [31:0] mem_inst_rdata
);

  localparam int LINE_WORDS = 1 << OFFSET_W;
  localparam int TAG_W      = 32 - INDEX_W - OFFSET_W - 2;
  localparam int LINE_W     = LINE_WORDS * 32;

  state_t state, state_nx;
  req_t   req_q;

  logic [OFFSET_W-1:0]         cnt;
  logic [LINE_WORDS-1:0][31:0] line_buf;
  logic [LINE_WORDS-1:0][31:0] fill_line;
  logic [LINE_WORDS-1:0][31:0] rd_words;
  logic                        inv_pending;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_off;
  logic                bypass;
  logic                hit;
  logic                accept;
  logic                last_word;
  logic                commit;
  logic                clr_all;

  logic              arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  logic [LINE_W-1:0] arr_line;

  assign req_tag   = req_q.addr[31 -: TAG_W];
  assign req_index = req_q.addr[OFFSET_W+2 +: INDEX_W];
  assign req_off   = req_q.addr[2 +: OFFSET_W];

  // Writes are never cached; kseg1 is uncached only when bypass is enabled.
  assign bypass    = req_q.wr || (BYPASS_EN && is_kseg1(req_q.addr));
  assign rd_words  = arr_line;
  assign hit       = arr_valid && (arr_tag == req_tag) && !bypass;

  // An invalidate, fresh or deferred, owns the first IDLE cycle.
  assign clr_all   = (state == S_IDLE) && (inv || inv_pending);
  assign accept    = (state == S_IDLE) && cpu_inst_req && !inv && !inv_pending;
  assign last_word = (cnt == OFFSET_W'(LINE_WORDS - 1));
  assign commit    = (state == S_RWAIT) && mem_inst_data_ok && last_word;

  always_comb begin
    fill_line      = line_buf;
    fill_line[cnt] = mem_inst_rdata;
  end

  i_cache_dm_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_all),
    .rd_index (req_index),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_line  (arr_line),
    .we       (commit),
    .wr_index (req_index),
    .wr_tag   (req_tag),
    .wr_line  (fill_line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_LOOKUP;
      S_LOOKUP: begin
        if (bypass)   state_nx = S_UNC;
        else if (hit) state_nx = S_IDLE;
        else          state_nx = S_REFILL;
      end
      S_REFILL: if (mem_inst_addr_ok) state_nx = S_RWAIT;
      S_RWAIT:  if (mem_inst_data_ok) state_nx = last_word ? S_RESP : S_REFILL;
      S_RESP:   state_nx = S_IDLE;
      S_UNC:    if (mem_inst_addr_ok) state_nx = S_UWAIT;
      S_UWAIT:  if (mem_inst_data_ok) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = '0;
    mem_inst_req     = 1'b0;
    mem_inst_wr      = 1'b0;
    mem_inst_size    = '0;
    mem_inst_addr    = '0;
    mem_inst_wdata   = '0;
    case (state)
      S_IDLE: cpu_inst_addr_ok = accept;
      S_LOOKUP: begin
        if (hit) begin
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = rd_words[req_off];
        end
      end
      S_REFILL: begin
        mem_inst_req  = 1'b1;
        mem_inst_size = SIZE_WORD;
        mem_inst_addr = {req_tag, req_index, cnt, 2'b00};
      end
      S_RESP: begin
        cpu_inst_data_ok = 1'b1;
        cpu_inst_rdata   = line_buf[req_off];
      end
      S_UNC: begin
        mem_inst_req   = 1'b1;
        mem_inst_wr    = req_q.wr;
        mem_inst_size  = req_q.size;
        mem_inst_addr  = req_q.addr;
        mem_inst_wdata = req_q.wdata;
      end
      S_UWAIT: begin
        if (mem_inst_data_ok) begin
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = mem_inst_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      cnt         <= '0;
      line_buf    <= '0;
      inv_pending <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= '{wr: cpu_inst_wr, size: cpu_inst_size, addr: cpu_inst_addr, wdata: cpu_inst_wdata};
      end
      if (state == S_LOOKUP && !hit && !bypass) begin
        cnt <= '0;
      end
      if (state == S_RWAIT && mem_inst_data_ok) begin
        line_buf[cnt] <= mem_inst_rdata;
        cnt           <= last_word ? '0 : cnt + OFFSET_W'(1);
      end
      // A busy-time invalidate waits until the in-flight access has answered.
      if (state == S_IDLE) begin
        inv_pending <= 1'b0;
      end else if (inv) begin
        inv_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i_cache_dm.sv
// Directed bench for i_cache_dm: vector table plus inv/reset/random-stall sequences.
module tb_i_cache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inv = 1'b0;
  logic        cpu_inst_req = 1'b0;
  logic        cpu_inst_wr = 1'b0;
  logic [1:0]  cpu_inst_size = 2'b10;
  logic [31:0] cpu_inst_addr = '0;
  logic [31:0] cpu_inst_wdata = '0;
  logic        cpu_inst_addr_ok, cpu_inst_data_ok;
  logic [31:0] cpu_inst_rdata;
  logic        mem_inst_req, mem_inst_wr;
  logic [1:0]  mem_inst_size;
  logic [31:0] mem_inst_addr, mem_inst_wdata;
  logic        mem_inst_addr_ok = 1'b0;
  logic        mem_inst_data_ok = 1'b0;
  logic [31:0] mem_inst_rdata = '0;

  i_cache_dm dut (
    .clk              (clk),
    .rst              (rst),
    .inv              (inv),
    .cpu_inst_req     (cpu_inst_req),
    .cpu_inst_wr      (cpu_inst_wr),
    .cpu_inst_size    (cpu_inst_size),
    .cpu_inst_addr    (cpu_inst_addr),
    .cpu_inst_wdata   (cpu_inst_wdata),
    .cpu_inst_addr_ok (cpu_inst_addr_ok),
    .cpu_inst_data_ok (cpu_inst_data_ok),
    .cpu_inst_rdata   (cpu_inst_rdata),
    .mem_inst_req     (mem_inst_req),
    .mem_inst_wr      (mem_inst_wr),
    .mem_inst_size    (mem_inst_size),
    .mem_inst_addr    (mem_inst_addr),
    .mem_inst_wdata   (mem_inst_wdata),
    .mem_inst_addr_ok (mem_inst_addr_ok),
    .mem_inst_data_ok (mem_inst_data_ok),
    .mem_inst_rdata   (mem_inst_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int amin = 0, amax = 0, dmin = 0, dmax = 0;
  logic [31:0] log_addr[$];
  logic        log_wr[$];
  int wt, wbase;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:16] ^ 16'h1234, a[15:2], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream memory: one outstanding access, programmable stalls.
  initial begin : responder
    logic        data_pend;
    logic        req_seen;
    logic [31:0] paddr, seen_addr;
    int          acnt, dcnt;
    data_pend = 1'b0;
    req_seen  = 1'b0;
    acnt = 0;
    dcnt = 0;
    forever begin
      @(negedge clk);
      mem_inst_addr_ok = 1'b0;
      mem_inst_data_ok = 1'b0;
      if (rst) begin
        data_pend = 1'b0;
        req_seen  = 1'b0;
        acnt = $urandom_range(amax, amin);
      end else begin
        if (req_seen) begin
          chk("mem_req_held", {31'b0, mem_inst_req}, 32'd1);
          chk("mem_addr_held", mem_inst_addr, seen_addr);
        end
        if (data_pend) begin
          if (dcnt == 0) begin
            mem_inst_data_ok = 1'b1;
            mem_inst_rdata   = mem_word(paddr);
            data_pend = 1'b0;
          end else begin
            dcnt--;
          end
        end else if (mem_inst_req) begin
          if (acnt == 0) begin
            mem_inst_addr_ok = 1'b1;
            paddr = mem_inst_addr;
            log_addr.push_back(mem_inst_addr);
            log_wr.push_back(mem_inst_wr);
            data_pend = 1'b1;
            req_seen  = 1'b0;
            dcnt = $urandom_range(dmax, dmin);
            acnt = $urandom_range(amax, amin);
          end else begin
            req_seen  = 1'b1;
            seen_addr = mem_inst_addr;
            acnt--;
          end
        end else begin
          req_seen = 1'b0;
        end
      end
    end
  end

  task automatic do_access(input logic [31:0] a, input logic w, output logic [31:0] rd,
                           output int lat, output int nreads);
    int base, t;
    base = log_addr.size();
    @(negedge clk);
    cpu_inst_req   = 1'b1;
    cpu_inst_addr  = a;
    cpu_inst_wr    = w;
    cpu_inst_wdata = ~a;
    cpu_inst_size  = 2'b10;
    t = 0;
    #1;
    while (!cpu_inst_addr_ok && t < 200) begin
      @(negedge clk); #1; t++;
    end
    chk("addr_ok_seen", {31'b0, cpu_inst_addr_ok}, 32'd1);
    @(negedge clk);
    cpu_inst_req = 1'b0;
    lat = 1;
    t = 0;
    #1;
    while (!cpu_inst_data_ok && t < 500) begin
      @(negedge clk); #1; lat++; t++;
    end
    chk("data_ok_seen", {31'b0, cpu_inst_data_ok}, 32'd1);
    rd = cpu_inst_rdata;
    nreads = log_addr.size() - base;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_addr_ok"}, {31'b0, cpu_inst_addr_ok}, 32'd0);
    chk({tag, "_data_ok"}, {31'b0, cpu_inst_data_ok}, 32'd0);
    chk({tag, "_rdata"}, cpu_inst_rdata, 32'd0);
    chk({tag, "_mem_req"}, {31'b0, mem_inst_req}, 32'd0);
    chk({tag, "_mem_wr"}, {31'b0, mem_inst_wr}, 32'd0);
    chk({tag, "_mem_size"}, {30'b0, mem_inst_size}, 32'd0);
    chk({tag, "_mem_addr"}, mem_inst_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_inst_wdata, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    int          reads;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[12];

  initial begin : main
    logic [31:0] rd, a;
    int lat, n, r;

    vt[0]  = '{32'h9FC0_0004, 1'b0, 4, 32'h8DF4_0004};  // cold miss
    vt[1]  = '{32'h9FC0_0008, 1'b0, 0, 32'h8DF4_0008};  // hit
    vt[2]  = '{32'h9FC0_000C, 1'b0, 0, 32'h8DF4_000C};
    vt[3]  = '{32'h9FC0_0404, 1'b0, 4, 32'h8DF4_0404};  // conflict, same index
    vt[4]  = '{32'h9FC0_0004, 1'b0, 4, 32'h8DF4_0004};  // evicted, misses again
    vt[5]  = '{32'hBFC0_0000, 1'b0, 1, 32'hADF4_0000};  // kseg1 bypass
    vt[6]  = '{32'hBFC0_0000, 1'b0, 1, 32'hADF4_0000};  // bypass never fills
    vt[7]  = '{32'h9FC0_0000, 1'b0, 0, 32'h8DF4_0000};
    vt[8]  = '{32'h9FC0_0010, 1'b0, 4, 32'h8DF4_0010};
    vt[9]  = '{32'h9FC0_0014, 1'b0, 0, 32'h8DF4_0014};
    vt[10] = '{32'h9FC0_0010, 1'b1, 1, 32'h8DF4_0010};  // write passes through
    vt[11] = '{32'h9FC0_0014, 1'b0, 0, 32'h8DF4_0014};

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_access(vt[i].addr, vt[i].wr, rd, lat, n);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("vec%0d_mem_reads", i), n, vt[i].reads);
      if (vt[i].reads == 0) chk($sformatf("vec%0d_hit_latency", i), lat, 32'd1);
    end

    // Refill order is linear from word 0; bypass and write show up as single accesses.
    chk("refill_addr0", log_addr[0], 32'h9FC0_0000);
    chk("refill_addr1", log_addr[1], 32'h9FC0_0004);
    chk("refill_addr2", log_addr[2], 32'h9FC0_0008);
    chk("refill_addr3", log_addr[3], 32'h9FC0_000C);
    chk("conflict_addr0", log_addr[4], 32'h9FC0_0400);
    chk("bypass_addr", log_addr[12], 32'hBFC0_0000);
    chk("bypass_wr_flag", {31'b0, log_wr[12]}, 32'd0);
    chk("write_addr", log_addr[18], 32'h9FC0_0010);
    chk("write_wr_flag", {31'b0, log_wr[18]}, 32'd1);

    // inv in IDLE blocks the accept that cycle and clears every line.
    @(negedge clk);
    inv = 1'b1;
    cpu_inst_req = 1'b1;
    cpu_inst_addr = 32'h9FC0_0010;
    cpu_inst_wr = 1'b0;
    #1;
    chk("inv_blocks_addr_ok", {31'b0, cpu_inst_addr_ok}, 32'd0);
    @(negedge clk);
    inv = 1'b0;
    cpu_inst_req = 1'b0;
    do_access(32'h9FC0_0014, 1'b0, rd, lat, n);
    chk("after_inv_reads", n, 32'd4);
    chk("after_inv_rdata", rd, 32'h8DF4_0014);
    do_access(32'h9FC0_0000, 1'b0, rd, lat, n);
    chk("after_inv_reads_set0", n, 32'd4);

    // inv raised while waiting for refill data.
    dmin = 3; dmax = 3;
    wbase = log_addr.size();
    fork
      do_access(32'h9FC0_0028, 1'b0, rd, lat, n);
      begin
        wt = 0;
        while (log_addr.size() == wbase && wt < 100) begin
          @(negedge clk); #2; wt++;
        end
        @(negedge clk);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
      end
    join
    chk("inv_busy_rdata", rd, 32'h8DF4_0028);
    chk("inv_busy_reads", n, 32'd4);
    do_access(32'h9FC0_0028, 1'b0, rd, lat, n);
    chk("inv_busy_reread_reads", n, 32'd4);
    chk("inv_busy_reread_rdata", rd, 32'h8DF4_0028);
    do_access(32'h9FC0_002C, 1'b0, rd, lat, n);
    chk("inv_busy_then_hit_reads", n, 32'd0);
    dmin = 0; dmax = 0;

    // Reset after two refill words have returned.
    wbase = log_addr.size();
    @(negedge clk);
    cpu_inst_req = 1'b1;
    cpu_inst_addr = 32'h9FC0_0034;
    wt = 0;
    #1;
    while (!cpu_inst_addr_ok && wt < 50) begin
      @(negedge clk); #1; wt++;
    end
    @(negedge clk);
    cpu_inst_req = 1'b0;
    wt = 0;
    while (log_addr.size() < wbase + 3 && wt < 100) begin
      @(negedge clk); #2; wt++;
    end
    chk("rst_mid_reads_started", log_addr.size() - wbase, 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    wbase = log_addr.size();
    do_access(32'h9FC0_0034, 1'b0, rd, lat, n);
    chk("rst_refill_reads", n, 32'd4);
    chk("rst_refill_rdata", rd, 32'h8DF4_0034);
    chk("rst_refill_addr0", log_addr[wbase], 32'h9FC0_0030);
    chk("rst_refill_addr3", log_addr[wbase + 3], 32'h9FC0_003C);

    // Random stalls against the memory model.
    amin = 0; amax = 5; dmin = 0; dmax = 5;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(5, 0);
      if (r == 5) a = 32'hBFC0_0000 | ($urandom_range(3, 0) << 2);
      else a = 32'h9FC0_0000 | ($urandom_range(1, 0) << 10) | (r << 4) | ($urandom_range(3, 0) << 2);
      do_access(a, 1'b0, rd, lat, n);
      chk($sformatf("rand%0d_rdata", i), rd, mem_word(a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
